// File: rtl/shell_hit_gen.sv
// Tank shell launcher/stepper: flies one shell across the 128x128 map and emits a hit or miss pulse.
// Optional re-arm delay after each shell is built when SHELL_COOLDOWN_EN is defined.
module shell_hit_gen #(
    parameter logic [23:0] STEP_DIV = 24'd1_000_000,
    parameter logic [7:0]  MAP_MAX  = 8'd127,
    parameter logic [7:0]  HIT_W    = 8'd4,
    parameter logic [7:0]  HIT_H    = 8'd6,
    parameter logic [23:0] COOLDOWN = 24'd2_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fire,
    input  logic [7:0] shoot_x,
    input  logic [7:0] shoot_y,
    input  logic [7:0] shoot_info,
    input  logic [7:0] tgt_x,
    input  logic [7:0] tgt_y,
    input  logic       tgt_burst,
    output logic       hit,
    output logic       miss,
    output logic       shell_active,
    output logic [7:0] shell_x,
    output logic [7:0] shell_y
);

    typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

    // dir = shoot_info[2:1]: 0 N, 1 E, 2 S, 3 W
    state_t      state;
    logic [1:0]  dir;
    logic [23:0] step_cnt;
    logic        launch_ok;
    logic        accept;
    logic        collide;
    logic        at_edge;
    logic        unused_info;

    assign unused_info = ^shoot_info[7:3];
    assign launch_ok   = fire && !shoot_info[0];

`ifdef SHELL_COOLDOWN_EN
    logic [23:0] cool_cnt;
    // the last COOL cycle doubles as IDLE so a held fire relaunches exactly COOLDOWN clocks after entry
    assign accept = launch_ok &&
                    ((state == IDLE) || ((state == COOL) && (cool_cnt == COOLDOWN - 24'd1)));
    localparam state_t DONE_STATE = COOL;
`else
    assign accept = launch_ok && (state == IDLE);
    localparam state_t DONE_STATE = IDLE;
`endif

    // 9-bit compare keeps tgt+HIT-1 from wrapping near the map edge
    always_comb begin
        collide = !tgt_burst &&
                  ({1'b0, shell_x} >= {1'b0, tgt_x}) &&
                  ({1'b0, shell_x} <= {1'b0, tgt_x} + {1'b0, HIT_W} - 9'd1) &&
                  ({1'b0, shell_y} >= {1'b0, tgt_y}) &&
                  ({1'b0, shell_y} <= {1'b0, tgt_y} + {1'b0, HIT_H} - 9'd1);
    end

    always_comb begin
        at_edge = 1'b0;
        case (dir)
            2'd0: at_edge = (shell_y == 8'd0);
            2'd1: at_edge = (shell_x >= MAP_MAX);
            2'd2: at_edge = (shell_y >= MAP_MAX);
            2'd3: at_edge = (shell_x == 8'd0);
            default: at_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            dir          <= 2'd0;
            step_cnt     <= 24'd0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            shell_active <= 1'b0;
            shell_x      <= 8'd0;
            shell_y      <= 8'd0;
`ifdef SHELL_COOLDOWN_EN
            cool_cnt     <= 24'd0;
`endif
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (accept) begin
                state        <= FLY;
                dir          <= shoot_info[2:1];
                step_cnt     <= 24'd0;
                shell_active <= 1'b1;
                shell_x      <= shoot_x;
                shell_y      <= shoot_y;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    FLY: begin
                        if (collide) begin
                            hit          <= 1'b1;
                            shell_active <= 1'b0;
                            state        <= DONE_STATE;
`ifdef SHELL_COOLDOWN_EN
                            cool_cnt     <= 24'd0;
`endif
                        end else if (step_cnt == STEP_DIV - 24'd1) begin
                            step_cnt <= 24'd0;
                            if (at_edge) begin
                                miss         <= 1'b1;
                                shell_active <= 1'b0;
                                state        <= DONE_STATE;
`ifdef SHELL_COOLDOWN_EN
                                cool_cnt     <= 24'd0;
`endif
                            end else begin
                                case (dir)
                                    2'd0: shell_y <= shell_y - 8'd1;
                                    2'd1: shell_x <= shell_x + 8'd1;
                                    2'd2: shell_y <= shell_y + 8'd1;
                                    default: shell_x <= shell_x - 8'd1;
                                endcase
                            end
                        end else begin
                            step_cnt <= step_cnt + 24'd1;
                        end
                    end
`ifdef SHELL_COOLDOWN_EN
                    COOL: begin
                        if (cool_cnt == COOLDOWN - 24'd1) state <= IDLE;
                        else cool_cnt <= cool_cnt + 24'd1;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shell_hit_gen.sv
// Directed bench for shell_hit_gen with STEP_DIV=4, COOLDOWN=8: launch, hit, miss, burst pass-through, reset.
module tb_shell_hit_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       fire;
    logic [7:0] shoot_x, shoot_y, shoot_info, tgt_x, tgt_y;
    logic       tgt_burst;
    logic       hit, miss, shell_active;
    logic [7:0] shell_x, shell_y;

    int checks = 0;
    int errors = 0;
    int hits_seen;
    int miss_seen;

    shell_hit_gen #(
        .STEP_DIV(24'd4), .MAP_MAX(8'd127), .HIT_W(8'd4), .HIT_H(8'd6), .COOLDOWN(24'd8)
    ) dut (
        .clock(clock), .reset(reset), .fire(fire),
        .shoot_x(shoot_x), .shoot_y(shoot_y), .shoot_info(shoot_info),
        .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_burst(tgt_burst),
        .hit(hit), .miss(miss), .shell_active(shell_active),
        .shell_x(shell_x), .shell_y(shell_y)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; fire = 1'b0;
        shoot_x = 8'd0; shoot_y = 8'd0; shoot_info = 8'd0;
        tgt_x = 8'd200; tgt_y = 8'd200; tgt_burst = 1'b0;
        tick(); tick();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_active", 32'(shell_active), 32'd0);
        check("rst_x", 32'(shell_x), 32'd0);
        check("rst_y", 32'(shell_y), 32'd0);
        reset = 1'b0;
        tick();

        // East shot into a target 20 cells away
        shoot_x = 8'd10; shoot_y = 8'd20; shoot_info = 8'b010;
        tgt_x = 8'd30; tgt_y = 8'd18;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("e_launch_active", 32'(shell_active), 32'd1);
        check("e_launch_x", 32'(shell_x), 32'd10);
        check("e_launch_y", 32'(shell_y), 32'd20);
        hits_seen = 0; miss_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            hits_seen += int'(hit);
            miss_seen += int'(miss);
        end
        check("e_x30", 32'(shell_x), 32'd30);
        check("e_early_hit", 32'(hits_seen), 32'd0);
        tick();
        check("e_hit", 32'(hit), 32'd1);
        check("e_hit_miss", 32'(miss), 32'd0);
        check("e_hit_inactive", 32'(shell_active), 32'd0);
        tick();
        check("e_hit_pulse_end", 32'(hit), 32'd0);

        // North shot off the top edge
        tgt_x = 8'd200; tgt_y = 8'd200;
        shoot_x = 8'd50; shoot_y = 8'd3; shoot_info = 8'b000;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("n_launch_y", 32'(shell_y), 32'd3);
        hits_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            hits_seen += int'(hit);
            if (i == 4)  check("n_y2", 32'(shell_y), 32'd2);
            if (i == 8)  check("n_y1", 32'(shell_y), 32'd1);
            if (i == 12) check("n_y0", 32'(shell_y), 32'd0);
            if (i == 12) check("n_no_miss_yet", 32'(miss), 32'd0);
        end
        check("n_miss", 32'(miss), 32'd1);
        check("n_inactive", 32'(shell_active), 32'd0);
        check("n_no_hit", 32'(hits_seen), 32'd0);
        tick();
        check("n_miss_pulse_end", 32'(miss), 32'd0);

        // Diagonal orientation is ignored
        shoot_info = 8'b011; fire = 1'b1;
        tick(); tick(); tick();
        check("diag_no_launch", 32'(shell_active), 32'd0);

        // Fire held during flight must not restart the shell
        shoot_x = 8'd50; shoot_y = 8'd100; shoot_info = 8'b000;
        tick();
        check("held_launch_y", 32'(shell_y), 32'd100);
        for (int i = 0; i < 6; i++) tick();
        check("held_active", 32'(shell_active), 32'd1);
        check("held_y99", 32'(shell_y), 32'd99);
        fire = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;

        // Bursting target is transparent; shell exits at x=127
        shoot_x = 8'd10; shoot_y = 8'd20; shoot_info = 8'b010;
        tgt_x = 8'd30; tgt_y = 8'd18; tgt_burst = 1'b1;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        hits_seen = 0;
        for (int i = 1; i <= 472; i++) begin
            tick();
            hits_seen += int'(hit);
            if (i == 468) check("burst_x127", 32'(shell_x), 32'd127);
            if (i == 468) check("burst_active", 32'(shell_active), 32'd1);
        end
        check("burst_miss", 32'(miss), 32'd1);
        check("burst_no_hit", 32'(hits_seen), 32'd0);
        tgt_burst = 1'b0;
        tgt_x = 8'd200; tgt_y = 8'd200;
        tick();

        // Reset mid-flight aborts silently; next fire uses fresh position
        fire = 1'b1;
        tick();
        fire = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        hits_seen = 0; miss_seen = 0;
        reset = 1'b1;
        tick(); hits_seen += int'(hit); miss_seen += int'(miss);
        tick(); hits_seen += int'(hit); miss_seen += int'(miss);
        check("midrst_active", 32'(shell_active), 32'd0);
        check("midrst_x", 32'(shell_x), 32'd0);
        check("midrst_y", 32'(shell_y), 32'd0);
        check("midrst_pulses", 32'(hits_seen + miss_seen), 32'd0);
        reset = 1'b0;
        shoot_x = 8'd60; shoot_y = 8'd70; shoot_info = 8'b100;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("relaunch_active", 32'(shell_active), 32'd1);
        check("relaunch_x", 32'(shell_x), 32'd60);
        check("relaunch_y", 32'(shell_y), 32'd70);
        reset = 1'b1; tick(); reset = 1'b0;

        // Spawn inside the box with fire held: hit one cycle later, then re-arm
        shoot_x = 8'd31; shoot_y = 8'd20; shoot_info = 8'b010;
        tgt_x = 8'd30; tgt_y = 8'd18;
        fire = 1'b1;
        tick();
        check("spawn_active", 32'(shell_active), 32'd1);
        tick();
        check("spawn_hit", 32'(hit), 32'd1);
        check("spawn_inactive", 32'(shell_active), 32'd0);
        tgt_x = 8'd200; tgt_y = 8'd200;
`ifdef SHELL_COOLDOWN_EN
        for (int i = 0; i < 7; i++) tick();
        check("cool_still_idle", 32'(shell_active), 32'd0);
        tick();
        check("cool_relaunch", 32'(shell_active), 32'd1);
`else
        tick();
        check("rearm_relaunch", 32'(shell_active), 32'd1);
        check("rearm_x", 32'(shell_x), 32'd31);
        check("rearm_hit_low", 32'(hit), 32'd0);
`endif
        fire = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
